inst_cache: RTL and testbench
=============================

Name: inst_cache

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage and a multi-cycle instruction memory.
- Takes the fetch PC and returns `inst` plus `hit`; the fetch stage advances PC only on `hit`, or every cycle when `cache_en` = 0.
- On a miss, a fill FSM fetches the whole line word-by-word over a req/ready memory handshake.

Parameters:
- LINES, 16: number of lines; power of 2, ≥ 2.
- WORDS_PER_LINE, 4: 32-bit words per line; power of 2, ≥ 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc  input  32  fetch address; word-aligned, pc[1:0] ignored.
- cache_en  input  1  1 = cached operation, 0 = bypass.
- flush  input  1  one-cycle pulse; invalidates all lines.
- inst  output  32  instruction for pc.
- hit  output  1  `inst` is valid from the cache this cycle.
- mem_req  output  1  memory read request.
- mem_addr  output  32  memory word address, byte-addressed, bits[1:0] = 0.
- mem_rdata  input  32  memory read data.
- mem_ready  input  1  `mem_rdata` is valid for `mem_addr`; consumes one word.

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE), IDX = log2(LINES).
  - Word offset = pc[OFF+1:2]; index = pc[IDX+OFF+1:OFF+2]; tag = the remaining upper bits.
- Storage: per line, 1 valid bit, one tag, WORDS_PER_LINE data words. Data and tag arrays are not reset.
- Reset (asynchronous, any state including mid-fill):
  - All valid bits cleared; state = IDLE.
  - `mem_req` = 0, `hit` = 0, `inst` = 0, fill word counter = 0.
- States: IDLE, FILL.
- IDLE, `cache_en` = 1:
  - `hit` = valid[index] && tag match, combinational in the same cycle.
  - `inst` = data word for pc on hit, else 0.
  - On a miss with `flush` = 0: latch the line base address (pc with the offset cleared) and index/tag, clear the counter, go to FILL.
- FILL:
  - `mem_req` = 1; `mem_addr` = line base + 4·counter.
  - Each cycle with `mem_ready` = 1: write `mem_rdata` to word[counter], counter += 1.
  - When the last word is accepted: set valid and tag for the line, go to IDLE.
  - `hit` = 0 for every FILL cycle, including the cycle the last word arrives.
  - The refilled access hits in the first IDLE cycle after the fill.
  - Miss-to-hit latency = WORDS_PER_LINE ready cycles + 1.
  - `pc` may change during FILL; the fill completes for the latched line regardless.
  - On re-entering IDLE, lookup uses the current `pc`.
- Bypass (`cache_en` = 0):
  - Only honoured in IDLE: `mem_addr` = {pc[31:2], 2'b00}, `mem_req` = 1, `inst` = `mem_rdata`, `hit` = 0.
  - No array writes; memory is treated as combinational in this mode.
  - `cache_en` falling during FILL has no effect until the fill completes.
- Flush:
  - In IDLE: all valid bits cleared at the clock edge; `hit` = 0 in that cycle; no miss is started that cycle.
  - In FILL: fill aborted, `mem_req` drops next cycle, the line is not validated, return to IDLE.
  - Flush and the last `mem_ready` in the same cycle: flush wins; line stays invalid.
- The line being filled never reports a hit before completion; partial lines are never visible.
- Outside FILL and bypass: `mem_req` = 0, `mem_addr` = 0.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- When defined:
  - Adds outputs `hit_count` [31:0] and `miss_count` [31:0], reset to 0.
  - `hit_count` += 1 on each IDLE cycle with `cache_en` && `hit`.
  - `miss_count` += 1 on each IDLE→FILL transition.
  - Both counters saturate at 32'hFFFF_FFFF; neither is cleared by flush.
- When undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Cold miss: after reset, cache_en = 1, pc = 0x0000_0104, memory word = address ^ 0xA5A5_0000, ready every cycle.
  -> hit = 0; mem_addr 0x100, 0x104, 0x108, 0x10C on consecutive cycles; hit = 1 and inst = 0xA5A5_0104 on cycle 6.
- Spatial hit after fill: pc = 0x0000_010C.
  -> same-cycle hit = 1, inst = 0xA5A5_010C, mem_req = 0.
- Conflict eviction: pc = 0x0000_1104 (same index 0, different tag).
  -> miss, refill from 0x1100; then pc = 0x104 misses again.
- Stalled memory: mem_ready toggles 1,0,0,1,1,0,1 during a fill.
  -> exactly 4 words accepted, counter advances only on ready, mem_req held high until done.
- Flush mid-fill: assert flush after 2 words.
  -> mem_req low the next cycle; the same pc then misses and restarts at word 0. Separately, async reset mid-fill -> mem_req = 0 immediately, no valid lines.
- Bypass: cache_en = 0, pc = 0x200, mem_rdata = 0x1234_5678.
  -> mem_addr = 0x200, inst = 0x1234_5678, hit = 0, no array update (a later cache_en = 1 access to 0x200 misses).
  - With ICACHE_STATS_EN: after the above sequence, counts match the hits/misses tallied by the scoreboard.

Source files
------------

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache; misses fill a whole line word-by-word over req/ready.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module inst_cache #(
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        cache_en,
    input  logic        flush,
    output logic [31:0] inst,
    output logic        hit,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned OFF   = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX   = $clog2(LINES);
    localparam int unsigned TAGW  = 30 - OFF - IDX;
    localparam int unsigned BASEW = 30 - OFF;
    localparam logic [OFF-1:0] CntLast = OFF'(WORDS_PER_LINE - 1);
    localparam logic [OFF-1:0] CntOne  = OFF'(1);

    typedef enum logic {StIdle, StFill} state_e;

    state_e           state_q, state_d;
    logic [OFF-1:0]   cnt_q, cnt_d;
    logic [BASEW-1:0] base_q, base_d;
    logic [LINES-1:0] valid_q, valid_d;

    logic [TAGW-1:0]  tag_mem  [LINES];
    logic [31:0]      data_mem [LINES*WORDS_PER_LINE];

    logic [OFF-1:0]   pc_off;
    logic [IDX-1:0]   pc_idx;
    logic [TAGW-1:0]  pc_tag;
    logic [IDX-1:0]   fill_idx;
    logic [TAGW-1:0]  fill_tag;
    logic             lookup_hit;
    logic             data_we;
    logic             tag_we;
    logic             unused_pc;

    assign pc_off     = pc[OFF+1:2];
    assign pc_idx     = pc[IDX+OFF+1:OFF+2];
    assign pc_tag     = pc[31:IDX+OFF+2];
    assign fill_idx   = base_q[IDX-1:0];
    assign fill_tag   = base_q[BASEW-1:IDX];
    assign lookup_hit = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign unused_pc  = ^pc[1:0];

    // Partial data may land in an invalid line; it only becomes visible once tag_we sets valid.
    assign data_we = (state_q == StFill) && mem_ready;
    assign tag_we  = (state_q == StFill) && mem_ready && (cnt_q == CntLast) && !flush;

    always_comb begin
        hit      = 1'b0;
        inst     = '0;
        mem_req  = 1'b0;
        mem_addr = '0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        valid_d  = valid_q;

        unique case (state_q)
            StIdle: begin
                if (cache_en) begin
                    hit = lookup_hit && !flush;
                    if (hit) begin
                        inst = data_mem[{pc_idx, pc_off}];
                    end else if (!flush) begin
                        state_d = StFill;
                        cnt_d   = '0;
                        base_d  = pc[31:OFF+2];
                    end
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = {pc[31:2], 2'b00};
                    inst     = mem_rdata;
                end
            end
            StFill: begin
                mem_req  = 1'b1;
                mem_addr = {base_q, cnt_q, 2'b00};
                if (flush) begin
                    state_d = StIdle;
                end else if (mem_ready) begin
                    cnt_d = cnt_q + CntOne;
                    if (cnt_q == CntLast) begin
                        state_d           = StIdle;
                        valid_d[fill_idx] = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            base_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[{fill_idx, cnt_q}] <= mem_rdata;
        end
        if (tag_we) begin
            tag_mem[fill_idx] <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if ((state_q == StIdle) && cache_en && hit && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if ((state_q == StIdle) && (state_d == StFill) && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: vector table for single-cycle lookups/bypass, plus
// scoreboarded fill sequences (expected fill addresses queued at miss, popped on each accepted word).
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        cache_en;
    logic        flush;
    logic [31:0] inst;
    logic        hit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        ovr_en;
    logic [31:0] ovr_data;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int          checks = 0;
    int          passed = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;
    int          last_cycles = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] pc;
        logic        en;
        logic        ovr;
        logic [31:0] rdata;
        logic        hit;
        logic [31:0] inst;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[6];

    inst_cache #(
        .LINES         (16),
        .WORDS_PER_LINE(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc),
        .cache_en (cache_en),
        .flush    (flush),
        .inst     (inst),
        .hit      (hit),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: each word holds its own address XOR a fixed pattern, unless overridden.
    always_comb mem_rdata = ovr_en ? ovr_data : (mem_addr ^ 32'hA5A5_0000);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic cycle_begin();
        @(posedge clk);
        #1;
    endtask

    task automatic start_miss(input logic [31:0] a, input string nm);
        cycle_begin();
        pc        = a;
        cache_en  = 1'b1;
        flush     = 1'b0;
        mem_ready = 1'b0;
        ovr_en    = 1'b0;
        @(negedge clk);
        check({nm, " miss hit"}, {31'b0, hit}, 32'd0);
        check({nm, " miss mem_req"}, {31'b0, mem_req}, 32'd0);
        exp_misses++;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({a[31:4], 4'h0} + 32'(4 * i));
    endtask

    task automatic fill_words(input logic [15:0] pat, input int len, input int nwords,
                              input string nm);
        int cyc;
        int got;
        cyc = 0;
        got = 0;
        while (got < nwords && cyc < 64) begin
            cycle_begin();
            mem_ready = pat[cyc % len];
            @(negedge clk);
            check({nm, " fill mem_req"}, {31'b0, mem_req}, 32'd1);
            check({nm, " fill hit"}, {31'b0, hit}, 32'd0);
            check({nm, " fill mem_addr"}, mem_addr, exp_q[0]);
            if (mem_ready) begin
                void'(exp_q.pop_front());
                got++;
            end
            cyc++;
        end
        check({nm, " words accepted"}, 32'(got), 32'(nwords));
        last_cycles = cyc;
    endtask

    task automatic finish_hit(input logic [31:0] a, input string nm);
        cycle_begin();
        mem_ready = 1'b0;
        @(negedge clk);
        check({nm, " refill hit"}, {31'b0, hit}, 32'd1);
        check({nm, " refill inst"}, inst, a ^ 32'hA5A5_0000);
        check({nm, " refill mem_req"}, {31'b0, mem_req}, 32'd0);
        exp_hits++;
    endtask

    task automatic do_miss(input logic [31:0] a, input logic [15:0] pat, input int len,
                           input string nm);
        start_miss(a, nm);
        fill_words(pat, len, 4, nm);
        finish_hit(a, nm);
    endtask

    // Miss, accept nwords, then pulse flush together with another ready word.
    task automatic flush_fill(input logic [31:0] a, input int nwords, input string nm);
        start_miss(a, nm);
        fill_words(16'h1, 1, nwords, nm);
        cycle_begin();
        mem_ready = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        check({nm, " flush-cycle mem_req"}, {31'b0, mem_req}, 32'd1);
        check({nm, " flush-cycle mem_addr"}, mem_addr, exp_q[0]);
        check({nm, " flush-cycle hit"}, {31'b0, hit}, 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_010C, 1'b1, 1'b0, 32'h0, 1'b1, 32'hA5A5_010C, 1'b0, 32'h0};
        vecs[1] = '{32'h0000_0100, 1'b1, 1'b0, 32'h0, 1'b1, 32'hA5A5_0100, 1'b0, 32'h0};
        vecs[2] = '{32'h0000_0108, 1'b1, 1'b0, 32'h0, 1'b1, 32'hA5A5_0108, 1'b0, 32'h0};
        vecs[3] = '{32'h0000_0200, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b1,
                    32'h0000_0200};
        vecs[4] = '{32'h0000_0107, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b1,
                    32'h0000_0104};
        vecs[5] = '{32'h0000_010E, 1'b1, 1'b0, 32'h0, 1'b1, 32'hA5A5_010C, 1'b0, 32'h0};

        rst       = 1'b1;
        pc        = 32'h0;
        cache_en  = 1'b1;
        flush     = 1'b0;
        mem_ready = 1'b0;
        ovr_en    = 1'b0;
        ovr_data  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset hit", {31'b0, hit}, 32'd0);
        check("reset inst", inst, 32'd0);
        check("reset mem_req", {31'b0, mem_req}, 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        cache_en = 1'b0;

        do_miss(32'h0000_0104, 16'h1, 1, "cold");
        check("cold fill cycles", 32'(last_cycles), 32'd4);

        for (int i = 0; i < 6; i++) begin
            cycle_begin();
            pc       = vecs[i].pc;
            cache_en = vecs[i].en;
            ovr_en   = vecs[i].ovr;
            ovr_data = vecs[i].rdata;
            @(negedge clk);
            check($sformatf("vec%0d hit", i), {31'b0, hit}, {31'b0, vecs[i].hit});
            check($sformatf("vec%0d inst", i), inst, vecs[i].inst);
            check($sformatf("vec%0d mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].req});
            check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].addr);
            if (vecs[i].en && vecs[i].hit) exp_hits++;
        end

        do_miss(32'h0000_0200, 16'h1, 1, "bypass no-alloc");
        do_miss(32'h0000_1104, 16'h1, 1, "conflict");
        do_miss(32'h0000_0104, 16'h1, 1, "conflict back");

        do_miss(32'h0000_0120, 16'b1011001, 7, "stall");
        check("stall fill cycles", 32'(last_cycles), 32'd7);

        flush_fill(32'h0000_0140, 2, "flush mid");
        do_miss(32'h0000_0140, 16'h1, 1, "flush mid refetch");

        flush_fill(32'h0000_0180, 3, "flush last");
        do_miss(32'h0000_0180, 16'h1, 1, "flush last refetch");

        cycle_begin();
        pc       = 32'h0000_0184;
        cache_en = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        check("idle flush hit", {31'b0, hit}, 32'd0);
        check("idle flush mem_req", {31'b0, mem_req}, 32'd0);
        do_miss(32'h0000_0184, 16'h1, 1, "idle flush");

        start_miss(32'h0000_01C0, "reset mid");
        fill_words(16'h1, 1, 2, "reset mid");
        cycle_begin();
        rst = 1'b1;
        #1;
        check("async reset mem_req", {31'b0, mem_req}, 32'd0);
        check("async reset hit", {31'b0, hit}, 32'd0);
        check("async reset inst", inst, 32'd0);
        exp_q.delete();
        exp_hits   = 0;
        exp_misses = 0;
        cache_en   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_miss(32'h0000_0184, 16'h1, 1, "post-reset");

        cycle_begin();
        cache_en = 1'b0;
        pc       = 32'h0;
        @(negedge clk);
`ifdef ICACHE_STATS_EN
        check("hit_count", hit_count, 32'(exp_hits));
        check("miss_count", miss_count, 32'(exp_misses));
`endif
        check("bypass final hit", {31'b0, hit}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
